controller_fsm: RTL and testbench

//  Multi-cycle control unit directly upstream of the 8-bit/13-bit-address datapath; drives every datapath control strobe.

---
 rtl/cpu_ctrl_pkg.sv | 75 +++++++
 rtl/ctrl_decoder.sv | 80 ++++++++
 rtl/controller_fsm.sv | 109 ++++++++++
 tb/tb_controller_fsm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multi-cycle controller: state encoding, opcode classes
// and the packed control word that carries every datapath strobe.
package cpu_ctrl_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F1,
    S_DEC,
    S_F2,
    S_F3,
    S_LD1,
    S_LD2,
    S_ST,
    S_JMP,
    S_EXA,
    S_F2I,
    S_EXI,
    S_WB,
    S_MOV
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MOV,
    CLS_ALUI,
    CLS_LOAD,
    CLS_STORE,
    CLS_JUMP
  } op_class_t;

  localparam logic [OPC_W-1:0] OPC_MOV  = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_ALUI = 4'b0111;

  // ir_op[2:1] after the third byte selects the memory/jump flavour
  localparam logic [1:0] SUB_LOAD  = 2'b00;
  localparam logic [1:0] SUB_STORE = 2'b01;
  localparam logic [1:0] SUB_JUMP  = 2'b10;

  typedef struct packed {
    logic ld_pc;
    logic ld_ir;
    logic ld_tr;
    logic ld_di;
    logic ld_alu;
    logic ld_czn;
    logic sel_mem_src_pc;
    logic sel_mem_src_tr;
    logic mem_write;
    logic sel_pc_src_jump;
    logic sel_ir_3_2;
    logic sel_ir_4_3;
    logic write_reg_en;
    logic sel_rf_write_src_tr_12_5;
    logic sel_write_src_reg1;
    logic sel_write_src_alu;
    logic sel_alu_src_reg1;
    logic sel_alu_src_tr;
    logic sel_czn_src_alu;
    logic sel_czn_src_rf;
  } ctrl_word_t;

  function automatic op_class_t op_class(input logic [OPC_W-1:0] op);
    op_class_t cls;
    if (op[3])                  cls = CLS_ALU;
    else if (op == OPC_MOV)     cls = CLS_MOV;
    else if (op == OPC_ALUI)    cls = CLS_ALUI;
    else if (op[2:1] == SUB_LOAD)  cls = CLS_LOAD;
    else if (op[2:1] == SUB_STORE) cls = CLS_STORE;
    else                        cls = CLS_JUMP;
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Moore output decode: maps the current controller state (and jump_cond while
// in JMP) onto the full set of datapath strobes. Purely combinational.
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic       jump_cond_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_IDLE: ;
      S_F1: begin
        ctrl_o.sel_mem_src_pc = 1'b1;
        ctrl_o.ld_ir          = 1'b1;
        ctrl_o.ld_pc          = 1'b1;
      end
      S_DEC: ;
      S_F2, S_F2I: begin
        ctrl_o.sel_mem_src_pc = 1'b1;
        ctrl_o.ld_tr          = 1'b1;
        ctrl_o.ld_pc          = 1'b1;
      end
      S_F3: begin
        ctrl_o.sel_mem_src_pc = 1'b1;
        ctrl_o.ld_di          = 1'b1;
        ctrl_o.ld_pc          = 1'b1;
      end
      S_LD1: begin
        ctrl_o.sel_mem_src_tr = 1'b1;
        ctrl_o.ld_tr          = 1'b1;
      end
      S_LD2: begin
        ctrl_o.write_reg_en             = 1'b1;
        ctrl_o.sel_rf_write_src_tr_12_5 = 1'b1;
        ctrl_o.sel_ir_4_3               = 1'b1;
      end
      S_ST: begin
        ctrl_o.sel_mem_src_tr = 1'b1;
        ctrl_o.mem_write      = 1'b1;
        ctrl_o.sel_ir_4_3     = 1'b1;
      end
      // Not-taken jumps need no PC load: PC already points past the third byte
      S_JMP: begin
        ctrl_o.sel_pc_src_jump = 1'b1;
        ctrl_o.ld_pc           = jump_cond_i;
      end
      S_EXA: begin
        ctrl_o.sel_alu_src_reg1 = 1'b1;
        ctrl_o.sel_ir_3_2       = 1'b1;
        ctrl_o.ld_alu           = 1'b1;
        ctrl_o.ld_czn           = 1'b1;
        ctrl_o.sel_czn_src_alu  = 1'b1;
      end
      S_EXI: begin
        ctrl_o.sel_alu_src_tr  = 1'b1;
        ctrl_o.sel_ir_3_2      = 1'b1;
        ctrl_o.ld_alu          = 1'b1;
        ctrl_o.ld_czn          = 1'b1;
        ctrl_o.sel_czn_src_alu = 1'b1;
      end
      S_WB: begin
        ctrl_o.write_reg_en      = 1'b1;
        ctrl_o.sel_write_src_alu = 1'b1;
        ctrl_o.sel_ir_3_2        = 1'b1;
      end
      S_MOV: begin
        ctrl_o.write_reg_en       = 1'b1;
        ctrl_o.sel_write_src_reg1 = 1'b1;
        ctrl_o.sel_ir_3_2         = 1'b1;
        ctrl_o.ld_czn             = 1'b1;
        ctrl_o.sel_czn_src_rf     = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/controller_fsm.sv
// Multi-cycle control unit: fetch (1-3 bytes), decode, execute and write-back
// for one instruction at a time. Holds the state register and next-state logic.
module controller_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] ir_op,
  input  logic                jump_cond,
  output logic                ld_PC,
  output logic                ld_IR,
  output logic                ld_TR,
  output logic                ld_DI,
  output logic                ld_ALU,
  output logic                ld_CZN,
  output logic                sel_MEM_src_PC,
  output logic                sel_MEM_src_TR,
  output logic                mem_write,
  output logic                sel_PC_src_JUMP,
  output logic                sel_IR_3_2,
  output logic                sel_IR_4_3,
  output logic                write_reg_en,
  output logic                sel_RF_write_src_TR_12_5,
  output logic                sel_writeSRC_reg1,
  output logic                sel_writeSRC_ALU,
  output logic                sel_ALU_src_reg1,
  output logic                sel_ALU_src_TR,
  output logic                sel_CZN_src_ALU,
  output logic                sel_CZN_src_RF
);

  state_t     state_q;
  state_t     state_d;
  op_class_t  op_cls;
  ctrl_word_t ctrl;

  assign op_cls = op_class(ir_op);

  // Async reset drops every strobe immediately, abandoning any instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_F1;
      S_F1:   state_d = S_DEC;
      S_DEC: begin
        case (op_cls)
          CLS_ALU:  state_d = S_EXA;
          CLS_MOV:  state_d = S_MOV;
          CLS_ALUI: state_d = S_F2I;
          default:  state_d = S_F2;
        endcase
      end
      S_F2:   state_d = S_F3;
      S_F3: begin
        case (ir_op[2:1])
          SUB_LOAD:  state_d = S_LD1;
          SUB_STORE: state_d = S_ST;
          SUB_JUMP:  state_d = S_JMP;
          default:   state_d = S_F1;
        endcase
      end
      S_LD1:  state_d = S_LD2;
      S_LD2:  state_d = S_F1;
      S_ST:   state_d = S_F1;
      S_JMP:  state_d = S_F1;
      S_EXA:  state_d = S_WB;
      S_F2I:  state_d = S_EXI;
      S_EXI:  state_d = S_WB;
      S_WB:   state_d = S_F1;
      S_MOV:  state_d = S_F1;
      default: state_d = S_IDLE;
    endcase
  end

  ctrl_decoder u_decoder (
    .state_i     (state_q),
    .jump_cond_i (jump_cond),
    .ctrl_o      (ctrl)
  );

  assign ld_PC                    = ctrl.ld_pc;
  assign ld_IR                    = ctrl.ld_ir;
  assign ld_TR                    = ctrl.ld_tr;
  assign ld_DI                    = ctrl.ld_di;
  assign ld_ALU                   = ctrl.ld_alu;
  assign ld_CZN                   = ctrl.ld_czn;
  assign sel_MEM_src_PC           = ctrl.sel_mem_src_pc;
  assign sel_MEM_src_TR           = ctrl.sel_mem_src_tr;
  assign mem_write                = ctrl.mem_write;
  assign sel_PC_src_JUMP          = ctrl.sel_pc_src_jump;
  assign sel_IR_3_2               = ctrl.sel_ir_3_2;
  assign sel_IR_4_3               = ctrl.sel_ir_4_3;
  assign write_reg_en             = ctrl.write_reg_en;
  assign sel_RF_write_src_TR_12_5 = ctrl.sel_rf_write_src_tr_12_5;
  assign sel_writeSRC_reg1        = ctrl.sel_write_src_reg1;
  assign sel_writeSRC_ALU         = ctrl.sel_write_src_alu;
  assign sel_ALU_src_reg1         = ctrl.sel_alu_src_reg1;
  assign sel_ALU_src_TR           = ctrl.sel_alu_src_tr;
  assign sel_CZN_src_ALU          = ctrl.sel_czn_src_alu;
  assign sel_CZN_src_RF           = ctrl.sel_czn_src_rf;

endmodule

// File: tb/tb_controller_fsm.sv
// Directed and random-opcode checks of the controller: per-cycle strobe words,
// per-class latency, select-group exclusivity and reset behaviour.
module tb_controller_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ir_op;
  logic       jump_cond;

  logic ld_PC, ld_IR, ld_TR, ld_DI, ld_ALU, ld_CZN;
  logic sel_MEM_src_PC, sel_MEM_src_TR, mem_write, sel_PC_src_JUMP;
  logic sel_IR_3_2, sel_IR_4_3, write_reg_en;
  logic sel_RF_write_src_TR_12_5, sel_writeSRC_reg1, sel_writeSRC_ALU;
  logic sel_ALU_src_reg1, sel_ALU_src_TR, sel_CZN_src_ALU, sel_CZN_src_RF;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  controller_fsm #(.OPCODE_W(4)) dut (
    .clk(clk), .rst(rst), .ir_op(ir_op), .jump_cond(jump_cond),
    .ld_PC(ld_PC), .ld_IR(ld_IR), .ld_TR(ld_TR), .ld_DI(ld_DI),
    .ld_ALU(ld_ALU), .ld_CZN(ld_CZN),
    .sel_MEM_src_PC(sel_MEM_src_PC), .sel_MEM_src_TR(sel_MEM_src_TR),
    .mem_write(mem_write), .sel_PC_src_JUMP(sel_PC_src_JUMP),
    .sel_IR_3_2(sel_IR_3_2), .sel_IR_4_3(sel_IR_4_3),
    .write_reg_en(write_reg_en),
    .sel_RF_write_src_TR_12_5(sel_RF_write_src_TR_12_5),
    .sel_writeSRC_reg1(sel_writeSRC_reg1), .sel_writeSRC_ALU(sel_writeSRC_ALU),
    .sel_ALU_src_reg1(sel_ALU_src_reg1), .sel_ALU_src_TR(sel_ALU_src_TR),
    .sel_CZN_src_ALU(sel_CZN_src_ALU), .sel_CZN_src_RF(sel_CZN_src_RF)
  );

  // Bench-side bit positions of each strobe in the observed word
  localparam logic [19:0] B_LDPC  = 20'h80000;
  localparam logic [19:0] B_LDIR  = 20'h40000;
  localparam logic [19:0] B_LDTR  = 20'h20000;
  localparam logic [19:0] B_LDDI  = 20'h10000;
  localparam logic [19:0] B_LDALU = 20'h08000;
  localparam logic [19:0] B_LDCZN = 20'h04000;
  localparam logic [19:0] B_MEMPC = 20'h02000;
  localparam logic [19:0] B_MEMTR = 20'h01000;
  localparam logic [19:0] B_MEMW  = 20'h00800;
  localparam logic [19:0] B_PCJ   = 20'h00400;
  localparam logic [19:0] B_IR32  = 20'h00200;
  localparam logic [19:0] B_IR43  = 20'h00100;
  localparam logic [19:0] B_WRE   = 20'h00080;
  localparam logic [19:0] B_RFTR  = 20'h00040;
  localparam logic [19:0] B_WR1   = 20'h00020;
  localparam logic [19:0] B_WALU  = 20'h00010;
  localparam logic [19:0] B_ALUR1 = 20'h00008;
  localparam logic [19:0] B_ALUTR = 20'h00004;
  localparam logic [19:0] B_CZNA  = 20'h00002;
  localparam logic [19:0] B_CZNR  = 20'h00001;

  localparam logic [19:0] W_ZERO = 20'h0;
  localparam logic [19:0] W_F1   = B_MEMPC | B_LDIR | B_LDPC;
  localparam logic [19:0] W_F2   = B_MEMPC | B_LDTR | B_LDPC;
  localparam logic [19:0] W_F3   = B_MEMPC | B_LDDI | B_LDPC;
  localparam logic [19:0] W_LD1  = B_MEMTR | B_LDTR;
  localparam logic [19:0] W_LD2  = B_WRE | B_RFTR | B_IR43;
  localparam logic [19:0] W_ST   = B_MEMTR | B_MEMW | B_IR43;
  localparam logic [19:0] W_JMP0 = B_PCJ;
  localparam logic [19:0] W_JMP1 = B_PCJ | B_LDPC;
  localparam logic [19:0] W_EXA  = B_ALUR1 | B_IR32 | B_LDALU | B_LDCZN | B_CZNA;
  localparam logic [19:0] W_EXI  = B_ALUTR | B_IR32 | B_LDALU | B_LDCZN | B_CZNA;
  localparam logic [19:0] W_WB   = B_WRE | B_WALU | B_IR32;
  localparam logic [19:0] W_MOV  = B_WRE | B_WR1 | B_IR32 | B_LDCZN | B_CZNR;

  logic [19:0] obs;
  assign obs = {ld_PC, ld_IR, ld_TR, ld_DI, ld_ALU, ld_CZN,
                sel_MEM_src_PC, sel_MEM_src_TR, mem_write, sel_PC_src_JUMP,
                sel_IR_3_2, sel_IR_4_3, write_reg_en,
                sel_RF_write_src_TR_12_5, sel_writeSRC_reg1, sel_writeSRC_ALU,
                sel_ALU_src_reg1, sel_ALU_src_TR, sel_CZN_src_ALU, sel_CZN_src_RF};

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  task automatic check_groups(input string tag);
    logic [19:0] multi;
    multi = {15'b0,
             ($countones({sel_MEM_src_PC, sel_MEM_src_TR}) > 1),
             ($countones({sel_RF_write_src_TR_12_5, sel_writeSRC_reg1, sel_writeSRC_ALU}) > 1),
             ($countones({sel_ALU_src_reg1, sel_ALU_src_TR}) > 1),
             ($countones({sel_CZN_src_ALU, sel_CZN_src_RF}) > 1),
             ($countones({sel_IR_3_2, sel_IR_4_3}) > 1)};
    check_val({tag, ":onehot"}, multi, 20'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects the DUT to sit in F1 on entry; leaves it in F1 on exit.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic jc);
    logic [19:0] seq [6];
    int n;
    ir_op     = op;
    jump_cond = jc;
    #1;
    check_val({tag, ":F1"}, obs, W_F1);
    check_groups(tag);
    for (int i = 0; i < 6; i++) seq[i] = W_F1;
    if (op[3]) begin
      seq[0] = W_ZERO; seq[1] = W_EXA; seq[2] = W_WB; n = 4;
    end else if (op == 4'b0110) begin
      seq[0] = W_ZERO; seq[1] = W_MOV; n = 3;
    end else if (op == 4'b0111) begin
      seq[0] = W_ZERO; seq[1] = W_F2; seq[2] = W_EXI; seq[3] = W_WB; n = 5;
    end else if (op[2:1] == 2'b00) begin
      seq[0] = W_ZERO; seq[1] = W_F2; seq[2] = W_F3; seq[3] = W_LD1; seq[4] = W_LD2; n = 6;
    end else if (op[2:1] == 2'b01) begin
      seq[0] = W_ZERO; seq[1] = W_F2; seq[2] = W_F3; seq[3] = W_ST; n = 5;
    end else begin
      seq[0] = W_ZERO; seq[1] = W_F2; seq[2] = W_F3; seq[3] = jc ? W_JMP1 : W_JMP0; n = 5;
    end
    for (int i = 0; i < n; i++) begin
      step();
      check_val($sformatf("%s:c%0d", tag, i + 1), obs, seq[i]);
      check_groups(tag);
    end
    $display("instr %s op=%b jc=%b cycles=%0d", tag, op, jc, n);
  endtask

  initial begin
    rst       = 1'b1;
    ir_op     = 4'b0000;
    jump_cond = 1'b0;
    step();
    check_val("rst_hold", obs, W_ZERO);
    step();
    check_val("rst_hold2", obs, W_ZERO);
    rst = 1'b0;
    #1;
    check_val("idle_after_rst", obs, W_ZERO);
    step();
    check_val("first_f1", obs, W_F1);

    run_instr("alu1010", 4'b1010, 1'b0);
    run_instr("load0000", 4'b0000, 1'b0);
    run_instr("store0010", 4'b0010, 1'b0);
    run_instr("jmp_nt", 4'b0100, 1'b0);
    run_instr("jmp_t", 4'b0100, 1'b1);
    run_instr("mov", 4'b0110, 1'b1);
    run_instr("alui", 4'b0111, 1'b0);
    run_instr("load0001", 4'b0001, 1'b1);
    run_instr("store0011", 4'b0011, 1'b1);
    run_instr("jmp0101", 4'b0101, 1'b1);
    run_instr("alu1111", 4'b1111, 1'b1);

    // Reset in the middle of LD2: write strobe must drop without a clock edge
    ir_op = 4'b0000;
    jump_cond = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_val("pre_rst_ld2", obs, W_LD2);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_mid_ld2", obs, W_ZERO);
    step();
    check_val("rst_mid_hold", obs, W_ZERO);
    rst = 1'b0;
    #1;
    check_val("idle_after_rst2", obs, W_ZERO);
    step();
    check_val("f1_after_rst2", obs, W_F1);
    $display("instr reset_mid_ld2 done");

    for (int k = 0; k < 1000; k++) begin
      logic [3:0] op;
      logic       jc;
      op = 4'($urandom_range(0, 15));
      jc = 1'($urandom_range(0, 1));
      run_instr($sformatf("rnd%0d", k), op, jc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
